dfp_panel_ctrl: RTL

Parametrised successor to the DFP front-panel controller on the DIN-41612 expansion bus. It decodes a 32-word I/O window and adds readable/writable light registers, a switch register, and a sticky error/status word. Halting is driven by a run/halt/step state machine controlled by both bus writes and panel buttons. The whole block runs synchronously on one clock; asynchronous bus strobes and panel inputs are synchronised internally.

---
 rtl/dfp_panel_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dfp_panel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dfp_panel_ctrl
// Purpose  : DFP front-panel controller: light/switch/status registers in a
//            32-word I/O window plus run/halt/step control of ec_nhalt.
// Revision : 1.0 - initial release
// ============================================================================
module dfp_panel_ctrl #(
    parameter logic [15:0] BASE        = 16'h0100,
    parameter int          NLIGHTS     = 4,
    parameter int          STEP_CYCLES = 8,
    parameter int          HALT_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           ec_ab,
    inout  wire  [15:0]           ec_db,
    input  logic                  ec_nio,
    input  logic                  ec_nr,
    input  logic                  ec_nw,
    input  logic                  ec_nsysdev,
    inout  wire                   ec_nhalt,
    input  logic [15:0]           sw,
    input  logic                  btn_run,
    input  logic                  btn_step,
    output logic [NLIGHTS*16-1:0] lights,
    output logic                  halted
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_HALTING = 2'd1,
        S_HALTED  = 2'd2,
        S_STEP    = 2'd3
    } state_t;

    localparam logic [4:0] c_OFF_SW     = 5'h10;
    localparam logic [4:0] c_OFF_HALT   = 5'h1d;
    localparam logic [4:0] c_OFF_STEP   = 5'h1e;
    localparam logic [4:0] c_OFF_STATUS = 5'h1f;
    localparam logic [7:0] c_STEP_LOAD  = 8'(STEP_CYCLES);

    logic r_nw_s1, r_nw_s2, r_nw_d;
    logic r_nr_s1, r_nr_s2, r_nr_d;
    logic r_run_s1, r_run_s2, r_run_d;
    logic r_stp_s1, r_stp_s2, r_stp_d;
    logic [15:0] r_sw_s1, r_sw_s2;

    logic [15:0]           r_light [NLIGHTS];
    state_t                r_state;
    logic [7:0]            r_timer;
    logic [7:0]            r_pending;
    logic [HALT_CNT_W-1:0] r_halt_cnt;
    logic                  r_err;
    logic                  r_stat_rd;
    logic                  r_nhalt_low;
    logic                  r_halted;

    logic        w_bus_sel, w_wr_ev, w_rd_fall, w_rd_rise, w_run_ev, w_stp_ev;
    logic        w_wr_halt, w_wr_step, w_wr_bad, w_is_light, w_pend_dec;
    logic [4:0]  w_off;
    logic [7:0]  w_cnt8;
    logic [9:0]  w_pend_sum;
    logic [7:0]  w_pend_next;
    logic [15:0] w_status, w_rd_data;

    // Strobe flops idle high, button/switch flops idle low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_nw_s1  <= 1'b1; r_nw_s2  <= 1'b1; r_nw_d  <= 1'b1;
            r_nr_s1  <= 1'b1; r_nr_s2  <= 1'b1; r_nr_d  <= 1'b1;
            r_run_s1 <= 1'b0; r_run_s2 <= 1'b0; r_run_d <= 1'b0;
            r_stp_s1 <= 1'b0; r_stp_s2 <= 1'b0; r_stp_d <= 1'b0;
            r_sw_s1  <= '0;   r_sw_s2  <= '0;
        end else begin
            r_nw_s1  <= ec_nw;    r_nw_s2  <= r_nw_s1;  r_nw_d  <= r_nw_s2;
            r_nr_s1  <= ec_nr;    r_nr_s2  <= r_nr_s1;  r_nr_d  <= r_nr_s2;
            r_run_s1 <= btn_run;  r_run_s2 <= r_run_s1; r_run_d <= r_run_s2;
            r_stp_s1 <= btn_step; r_stp_s2 <= r_stp_s1; r_stp_d <= r_stp_s2;
            r_sw_s1  <= sw;       r_sw_s2  <= r_sw_s1;
        end
    end

    assign w_off     = ec_ab[4:0];
    assign w_bus_sel = ((ec_ab & 16'hffe0) == BASE) && !ec_nio && !ec_nsysdev;
    assign w_wr_ev   = r_nw_d && !r_nw_s2 && w_bus_sel;
    assign w_rd_fall = r_nr_d && !r_nr_s2;
    assign w_rd_rise = !r_nr_d && r_nr_s2;
    assign w_run_ev  = r_run_s2 && !r_run_d;
    assign w_stp_ev  = r_stp_s2 && !r_stp_d;

    assign w_wr_halt = w_wr_ev && (w_off == c_OFF_HALT);
    assign w_wr_step = w_wr_ev && (w_off == c_OFF_STEP);
    assign w_wr_bad  = w_wr_ev && !w_is_light && (w_off != c_OFF_HALT) && (w_off != c_OFF_STEP);

    assign w_cnt8   = 8'(r_halt_cnt);
    assign w_status = {2'(r_state), r_err, 5'b0, w_cnt8};

    always_comb begin
        w_is_light = 1'b0;
        w_rd_data  = '0;
        for (int i = 0; i < NLIGHTS; i++) begin
            if (w_off == 5'(i)) begin
                w_is_light = 1'b1;
                w_rd_data  = r_light[i];
            end
        end
        if (w_off == c_OFF_SW)     w_rd_data = r_sw_s2;
        if (w_off == c_OFF_STATUS) w_rd_data = w_status;
    end

    assign ec_db    = (!ec_nr && w_bus_sel) ? w_rd_data : 16'hzzzz;
    assign ec_nhalt = r_nhalt_low ? 1'b0 : 1'bz;
    assign halted   = r_halted;

    generate
        for (genvar g = 0; g < NLIGHTS; g++) begin : g_lights
            assign lights[16*g +: 16] = r_light[g];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NLIGHTS; i++) r_light[i] <= '0;
        end else if (w_wr_ev) begin
            for (int i = 0; i < NLIGHTS; i++) begin
                if (w_off == 5'(i)) r_light[i] <= ec_db;
            end
        end
    end

    // The address is gone by the time the synchronised strobe rises, so the
    // STATUS decode is captured on the falling edge and consumed on the rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err     <= 1'b0;
            r_stat_rd <= 1'b0;
        end else begin
            if (w_rd_fall) r_stat_rd <= w_bus_sel && (w_off == c_OFF_STATUS);
            if (w_rd_rise) r_stat_rd <= 1'b0;
            if (w_wr_bad)
                r_err <= 1'b1;
            else if (w_rd_rise && r_stat_rd)
                r_err <= 1'b0;
        end
    end

    assign w_pend_dec  = (r_state == S_HALTED) && !w_run_ev && !w_stp_ev && (r_pending != 8'd0);
    assign w_pend_sum  = {2'b0, r_pending} + (w_wr_step ? {2'b0, ec_db[7:0]} : 10'd0)
                         - {9'd0, w_pend_dec};
    assign w_pend_next = (w_pend_sum > 10'd255) ? 8'hff : w_pend_sum[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_timer     <= '0;
            r_pending   <= '0;
            r_halt_cnt  <= '0;
            r_nhalt_low <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_nhalt_low <= (r_state == S_HALTING) || (r_state == S_HALTED);
            r_halted    <= (r_state == S_HALTED);
            r_pending   <= w_pend_next;
            case (r_state)
                S_RUN: begin
                    if (w_wr_halt || w_run_ev) r_state <= S_HALTING;
                end
                S_HALTING: begin
                    r_halt_cnt <= r_halt_cnt + 1'b1;
                    r_state    <= S_HALTED;
                end
                S_HALTED: begin
                    if (w_run_ev) begin
                        r_state   <= S_RUN;
                        r_pending <= '0;
                    end else if (w_stp_ev || (r_pending != 8'd0)) begin
                        r_state <= S_STEP;
                        r_timer <= c_STEP_LOAD;
                    end
                end
                S_STEP: begin
                    if (w_wr_halt) begin
                        r_state   <= S_HALTING;
                        r_pending <= '0;
                    end else if (r_timer == 8'd1) begin
                        r_state <= S_HALTING;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

endmodule
`default_nettype wire
